stage_8_depermutation: RTL and testbench

STAGE_8_DEPERMUTATION -- requirements
Module: stage_8_depermutation

---
 rtl/stage_8_depermutation.sv | 165 ++++++++++++++++
 tb/tb_stage_8_depermutation.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_8_depermutation.sv
// Inverse stride-P permutation: a frame of B beats is transposed so output beat b', lane l' holds element l'*B+b'.
// Latency: output beat 0 is registered B cycles after the in_start beat; later beats and back-to-back frames follow contiguously.
// Backpressure: none; ping-pong banks sustain one frame every B cycles while the other bank drains.
module stage_8_depermutation #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE      = 128,
   parameter int FRAME_SIZE           = 1024
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] inData,
   input  logic                                           in_start,
   output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] outData,
   output logic                                           out_start,
   output logic                                           out_valid
);
   localparam int W  = DATA_WIDTH_PER_INPUT;
   localparam int P  = INPUT_PER_CYCLE;
   localparam int B  = FRAME_SIZE / INPUT_PER_CYCLE;
   localparam int CW = (B > 1) ? $clog2(B) : 1;
   localparam int LW = (P > 1) ? $clog2(P) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);

   typedef enum logic {W_IDLE, W_FILL}  wState_t;
   typedef enum logic {R_IDLE, R_DRAIN} rState_t;

   wState_t       wState, wStateNext;
   logic [CW-1:0] wCnt, wCntNext;
   logic          wBank, wBankNext;
   logic          wrEn, frameDone;

   rState_t       rState, rStateNext;
   logic [CW-1:0] rCnt, rCntNext;
   logic          rBank, rBankNext;
   logic          loadOut;

   // One row per input beat; two banks for ping-pong operation
   logic [P*W-1:0] bankMem [2][B];
   logic [P*W-1:0] gathered;
   int             srcIdx;
   logic [CW-1:0]  srcBeat;
   logic [LW-1:0]  srcLane;

   // Write FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wState <= W_IDLE;
         wCnt   <= '0;
         wBank  <= 1'b0;
      end else begin
         wState <= wStateNext;
         wCnt   <= wCntNext;
         wBank  <= wBankNext;
      end
   end

   // Write FSM next state: start on in_start, ignore further starts until the last beat is in
   always_comb begin
      wStateNext = wState;
      wCntNext   = wCnt;
      wBankNext  = wBank;
      case (wState)
         W_IDLE: begin
            if (in_start) begin
               wStateNext = W_FILL;
               wCntNext   = CW'(1);
            end
         end
         W_FILL: begin
            if (wCnt == LAST_BEAT) begin
               wStateNext = W_IDLE;
               wCntNext   = '0;
               wBankNext  = ~wBank;
            end else begin
               wCntNext = wCnt + 1'b1;
            end
         end
         default: wStateNext = W_IDLE;
      endcase
   end

   // Write FSM outputs: beat write enable and frame-complete strobe
   always_comb begin
      wrEn      = 1'b0;
      frameDone = 1'b0;
      case (wState)
         W_IDLE: wrEn = in_start;
         W_FILL: begin
            wrEn      = 1'b1;
            frameDone = (wCnt == LAST_BEAT);
         end
         default: ;
      endcase
   end

   // Bank storage write; contents are only read after a full frame lands, so no reset
   always_ff @(posedge clk) begin
      if (wrEn) bankMem[wBank][wCnt] <= inData;
   end

   // Read FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rState <= R_IDLE;
         rCnt   <= '0;
         rBank  <= 1'b0;
      end else begin
         rState <= rStateNext;
         rCnt   <= rCntNext;
         rBank  <= rBankNext;
      end
   end

   // Read FSM next state: a completed bank restarts the drain even on the last beat of the previous one
   always_comb begin
      rStateNext = rState;
      rCntNext   = rCnt;
      rBankNext  = rBank;
      if (frameDone) begin
         rStateNext = R_DRAIN;
         rCntNext   = '0;
         rBankNext  = wBank;
      end else if (rState == R_DRAIN) begin
         if (rCnt == LAST_BEAT) begin
            rStateNext = R_IDLE;
            rCntNext   = '0;
         end else begin
            rCntNext = rCnt + 1'b1;
         end
      end
   end

   // Read FSM outputs: load the output register while draining
   always_comb begin
      loadOut = (rState == R_DRAIN);
   end

   // Gather output beat rCnt: lane l' takes element l'*B + rCnt of the frame
   always_comb begin
      gathered = '0;
      srcIdx   = 0;
      srcBeat  = '0;
      srcLane  = '0;
      for (int lp = 0; lp < P; lp++) begin
         srcIdx  = lp * B + int'(rCnt);
         srcBeat = CW'(srcIdx / P);
         srcLane = LW'(srcIdx % P);
         gathered[lp*W +: W] = bankMem[rBank][srcBeat][int'(srcLane)*W +: W];
      end
   end

   // Output register: holds last beat when idle, start flags beat 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outData   <= '0;
         out_start <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= loadOut;
         out_start <= loadOut && (rCnt == '0);
         if (loadOut) outData <= gathered;
      end
   end

endmodule

// File: tb/tb_stage_8_depermutation.sv
// Self-checking bench for stage_8_depermutation: scoreboard of expected output beats plus spot checks.
// Latency: expected beats are queued when a frame's in_start is driven and compared on their due cycle.
// Backpressure: none; idle cycles must show out_valid=0, out_start=0 and held outData.
module tb_stage_8_depermutation;
   localparam int W  = 28;
   localparam int P  = 128;
   localparam int N  = 1024;
   localparam int B  = N / P;
   localparam int DW = P * W;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_start = 1'b0;
   logic [DW-1:0] inData = '0;
   logic [DW-1:0] outData;
   logic          out_start;
   logic          out_valid;

   stage_8_depermutation #(
      .DATA_WIDTH_PER_INPUT(W),
      .INPUT_PER_CYCLE(P),
      .FRAME_SIZE(N)
   ) dut (
      .clk(clk),
      .rst(rst),
      .inData(inData),
      .in_start(in_start),
      .outData(outData),
      .out_start(out_start),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic          st;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          sbq[$];
   int            checks = 0;
   int            errors = 0;
   int            edgeNo = 0;
   logic [DW-1:0] heldOut = '0;

   function automatic logic [W-1:0] lane_of(input logic [DW-1:0] v, input int l);
      return v[l*W +: W];
   endfunction

   function automatic logic [DW-1:0] ramp_beat(input int base, input int b);
      logic [DW-1:0] v;
      v = '0;
      for (int l = 0; l < P; l++) v[l*W +: W] = W'(base + b*P + l);
      return v;
   endfunction

   function automatic logic [DW-1:0] width_beat(input int b);
      logic [DW-1:0] v;
      v = '0;
      if (b == 3) v = '1;
      return v;
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] v;
      v = '0;
      for (int l = 0; l < P; l++) v[l*W +: W] = W'($urandom);
      return v;
   endfunction

   // Frame element n: kind 0 = ramp from base, kind 1 = all ones in input beat 3 only
   function automatic logic [W-1:0] elem(input int kind, input int base, input int n);
      if (kind == 0) return W'(base + n);
      return (n / P == 3) ? {W{1'b1}} : {W{1'b0}};
   endfunction

   task automatic push_frame(input int t0, input int kind, input int base);
      exp_t e;
      for (int bp = 0; bp < B; bp++) begin
         e.cyc = t0 + B + bp;
         e.st  = (bp == 0);
         e.d   = '0;
         for (int lp = 0; lp < P; lp++) e.d[lp*W +: W] = elem(kind, base, lp*B + bp);
         sbq.push_back(e);
      end
   endtask

   task automatic tick(input logic [DW-1:0] d, input logic s);
      inData   = d;
      in_start = s;
      @(posedge clk);
      #1;
      edgeNo++;
   endtask

   task automatic test_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
         edgeNo++;
      end
      checks++;
      if (outData !== '0 || out_start !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold valid=%b start=%b lane0=%0h want all zero", out_valid, out_start, lane_of(outData, 0));
      end
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick(rand_beat(), 1'b0);
         checks++;
         if (outData !== '0 || out_start !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle c=%0d valid=%b start=%b lane0=%0h want all zero", c, out_valid, out_start, lane_of(outData, 0));
         end
      end
   endtask

   // Generic frame runner body used by ramp/spurious/width tests
   task automatic test_frame(input int kind, input logic spurious);
      exp_t e;
      logic [DW-1:0] d;
      logic s;
      int starts;
      starts = 0;
      for (int c = 0; c < 2*B + 3; c++) begin
         if (c < B) begin
            d = (kind == 0) ? ramp_beat(0, c) : width_beat(c);
            s = (c == 0) || (spurious && c == 3);
         end else begin
            d = rand_beat();
            s = 1'b0;
         end
         tick(d, s);
         if (c == 0) push_frame(edgeNo, kind, 0);
         if (out_start === 1'b1) starts++;
         checks++;
         if (sbq.size() != 0 && sbq[0].cyc == edgeNo) begin
            e = sbq.pop_front();
            if (out_valid !== 1'b1 || out_start !== e.st || outData !== e.d) begin
               errors++;
               $display("FAIL frame_beat kind=%0d c=%0d valid=%b start=%b lane0=%0h lane127=%0h want valid=1 start=%b lane0=%0h lane127=%0h",
                        kind, c, out_valid, out_start, lane_of(outData, 0), lane_of(outData, 127), e.st, lane_of(e.d, 0), lane_of(e.d, 127));
            end
            heldOut = e.d;
         end else if (out_valid !== 1'b0 || out_start !== 1'b0 || outData !== heldOut) begin
            errors++;
            $display("FAIL frame_idle kind=%0d c=%0d valid=%b start=%b lane0=%0h want valid=0 start=0 lane0=%0h",
                     kind, c, out_valid, out_start, lane_of(outData, 0), lane_of(heldOut, 0));
         end
         if (kind == 0 && c == B) begin
            checks++;
            if (out_start !== 1'b1 || lane_of(outData, 0) !== 28'd0 || lane_of(outData, 1) !== 28'd8 || lane_of(outData, 127) !== 28'd1016) begin
               errors++;
               $display("FAIL ramp_first start=%b l0=%0d l1=%0d l127=%0d want 1/0/8/1016",
                        out_start, lane_of(outData, 0), lane_of(outData, 1), lane_of(outData, 127));
            end
         end
         if (kind == 0 && c == 2*B - 1) begin
            checks++;
            if (lane_of(outData, 0) !== 28'd7 || lane_of(outData, 127) !== 28'd1023) begin
               errors++;
               $display("FAIL ramp_last l0=%0d l127=%0d want 7/1023", lane_of(outData, 0), lane_of(outData, 127));
            end
         end
         if (c == 2*B) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL valid_drop valid=%b want 0", out_valid);
            end
         end
         if (kind == 1 && (c == B || c == 2*B - 1)) begin
            checks++;
            if (lane_of(outData, 47) !== 28'h0 || lane_of(outData, 48) !== 28'hFFFFFFF ||
                lane_of(outData, 63) !== 28'hFFFFFFF || lane_of(outData, 64) !== 28'h0) begin
               errors++;
               $display("FAIL width_lanes c=%0d l47=%0h l48=%0h l63=%0h l64=%0h want 0/fffffff/fffffff/0",
                        c, lane_of(outData, 47), lane_of(outData, 48), lane_of(outData, 63), lane_of(outData, 64));
            end
         end
      end
      checks++;
      if (starts != 1 || sbq.size() != 0) begin
         errors++;
         $display("FAIL frame_starts kind=%0d starts=%0d left=%0d want 1/0", kind, starts, sbq.size());
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [DW-1:0] d;
      logic s;
      int validCnt;
      validCnt = 0;
      for (int c = 0; c < 3*B + 3; c++) begin
         if (c < 2*B) begin
            d = ramp_beat(0, c);
            s = (c == 0) || (c == B);
         end else begin
            d = rand_beat();
            s = 1'b0;
         end
         tick(d, s);
         if (c == 0) push_frame(edgeNo, 0, 0);
         if (c == B) push_frame(edgeNo, 0, N);
         if (out_valid === 1'b1) validCnt++;
         checks++;
         if (sbq.size() != 0 && sbq[0].cyc == edgeNo) begin
            e = sbq.pop_front();
            if (out_valid !== 1'b1 || out_start !== e.st || outData !== e.d) begin
               errors++;
               $display("FAIL b2b_beat c=%0d valid=%b start=%b lane1=%0h want valid=1 start=%b lane1=%0h",
                        c, out_valid, out_start, lane_of(outData, 1), e.st, lane_of(e.d, 1));
            end
            heldOut = e.d;
         end else if (out_valid !== 1'b0 || out_start !== 1'b0 || outData !== heldOut) begin
            errors++;
            $display("FAIL b2b_idle c=%0d valid=%b start=%b want valid=0 start=0 held", c, out_valid, out_start);
         end
         if (c == 2*B) begin
            checks++;
            if (out_start !== 1'b1 || out_valid !== 1'b1 || lane_of(outData, 1) !== 28'd1032) begin
               errors++;
               $display("FAIL b2b_second start=%b valid=%b lane1=%0d want 1/1/1032", out_start, out_valid, lane_of(outData, 1));
            end
         end
      end
      checks++;
      if (validCnt != 2*B || sbq.size() != 0) begin
         errors++;
         $display("FAIL b2b_valid_count got=%0d left=%0d want %0d/0", validCnt, sbq.size(), 2*B);
      end
   endtask

   // Two frames in flight (one draining, one filling), then a one-cycle reset
   task automatic test_reset_midframe();
      exp_t e;
      for (int c = 0; c < B + 4; c++) begin
         tick(ramp_beat(0, c), (c == 0) || (c == B));
         if (c == 0) push_frame(edgeNo, 0, 0);
         checks++;
         if (sbq.size() != 0 && sbq[0].cyc == edgeNo) begin
            e = sbq.pop_front();
            if (out_valid !== 1'b1 || out_start !== e.st || outData !== e.d) begin
               errors++;
               $display("FAIL midrst_beat c=%0d valid=%b start=%b lane0=%0h want valid=1 start=%b lane0=%0h",
                        c, out_valid, out_start, lane_of(outData, 0), e.st, lane_of(e.d, 0));
            end
            heldOut = e.d;
         end else if (out_valid !== 1'b0 || out_start !== 1'b0 || outData !== heldOut) begin
            errors++;
            $display("FAIL midrst_idle c=%0d valid=%b start=%b want valid=0 start=0 held", c, out_valid, out_start);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (outData !== '0 || out_start !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async valid=%b start=%b lane0=%0h want all zero", out_valid, out_start, lane_of(outData, 0));
      end
      sbq.delete();
      heldOut = '0;
      @(posedge clk);
      #1;
      edgeNo++;
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_frame(0, 1'b0);
      test_frame(0, 1'b1);
      test_back_to_back();
      test_frame(1, 1'b0);
      test_reset_midframe();
      test_frame(0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
